// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared word size, sequential PC step and the fetch
// FSM state encodings used by the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int WORD_SIZE = 16;
  localparam int PC_STEP   = 1;

  // Fixed 2-bit encodings kept identical to the legacy state values.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage sitting after program_counter. Issues a
// single-cycle-latency instruction-memory read at the current PC, advances
// or redirects the PC, and hands the fetched word to decode on valid/ready.
// One fetch in flight; three cycles per instruction with decode always ready.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   pc                           current PC from program_counter
//   pc_update_enable/pc_set_enable/pc_value  PC controls to program_counter
//   mem_read_enable, mem_address read strobe and address (address == pc)
//   mem_data                     read data, valid one cycle after the strobe
//   branch_enable, branch_target single-cycle redirect request and address
//   halt                         stop issuing new fetches
//   instr_valid/instr_ready      handshake to decode
//   instr_out, instr_pc          registered instruction and its address
//   fetch_count                  completed handshakes, wraps
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int WORD_SIZE = instruction_fetch_pkg::WORD_SIZE,
  parameter int PC_STEP   = instruction_fetch_pkg::PC_STEP
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] pc,
  output logic                 pc_update_enable,
  output logic                 pc_set_enable,
  output logic [WORD_SIZE-1:0] pc_value,
  output logic                 mem_read_enable,
  output logic [WORD_SIZE-1:0] mem_address,
  input  logic [WORD_SIZE-1:0] mem_data,
  input  logic                 branch_enable,
  input  logic [WORD_SIZE-1:0] branch_target,
  input  logic                 halt,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [WORD_SIZE-1:0] instr_out,
  output logic [WORD_SIZE-1:0] instr_pc,
  output logic [WORD_SIZE-1:0] fetch_count
);

  localparam logic [WORD_SIZE-1:0] STEP = WORD_SIZE'(PC_STEP);

  logic [1:0]           state;
  logic [WORD_SIZE-1:0] issued_pc;
  logic                 handshake;

  assign mem_address = pc;
  assign handshake   = (state == S_HOLD) && instr_ready;

  // PC controls are combinational; reset masks them so a branch pulse
  // coinciding with reset cannot move the PC.
  always_comb begin
    pc_set_enable    = !reset && branch_enable;
    pc_update_enable = !reset && !branch_enable && (state == S_ISSUE);
    mem_read_enable  = !reset && (state == S_ISSUE);
    pc_value         = '0;
    if (pc_set_enable)
      pc_value = branch_target;
    else if (pc_update_enable)
      pc_value = STEP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      issued_pc   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (handshake)
        fetch_count <= fetch_count + WORD_SIZE'(1);

      unique case (state)
        S_IDLE:  state <= halt ? S_IDLE : S_ISSUE;
        S_ISSUE: begin
          issued_pc <= pc;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          // A redirect in this cycle drops the returning word.
          if (!branch_enable) begin
            instr_out   <= mem_data;
            instr_pc    <= issued_pc;
            instr_valid <= 1'b1;
          end
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready || branch_enable)
            instr_valid <= 1'b0;
          if (instr_ready)
            state <= halt ? S_IDLE : S_ISSUE;
        end
        default: state <= S_IDLE;
      endcase

      // Redirect overrides whatever the state decode chose above.
      if (branch_enable)
        state <= halt ? S_IDLE : S_ISSUE;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: drives a simple program_counter model and an
// instruction memory returning 0xA000|addr one cycle after each read.
module tb_instruction_fetch;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         pc_rst;
  logic [W-1:0] pc;
  logic         pc_update_enable, pc_set_enable, mem_read_enable;
  logic [W-1:0] pc_value, mem_address, mem_data;
  logic         branch_enable, halt, instr_valid, instr_ready;
  logic [W-1:0] branch_target, instr_out, instr_pc, fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.WORD_SIZE(W), .PC_STEP(1)) dut (
    .clock(clock), .reset(reset), .pc(pc),
    .pc_update_enable(pc_update_enable), .pc_set_enable(pc_set_enable),
    .pc_value(pc_value), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_data(mem_data),
    .branch_enable(branch_enable), .branch_target(branch_target),
    .halt(halt), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_out(instr_out), .instr_pc(instr_pc), .fetch_count(fetch_count)
  );

  // Environment: program counter with its own reset, and instruction memory.
  always_ff @(posedge clock) begin
    if (pc_rst)                pc <= '0;
    else if (pc_set_enable)    pc <= pc_value;
    else if (pc_update_enable) pc <= pc + pc_value;
  end

  always_ff @(posedge clock)
    if (mem_read_enable) mem_data <= 16'hA000 | mem_address;

  typedef struct {
    logic         halt, ready, br;
    logic [W-1:0] tgt;
    logic         rd, upd, set;
    logic [W-1:0] pcv, addr;
    logic         valid;
    logic [W-1:0] out, ipc, cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change just after the falling edge, outputs are
  // checked 1 time unit later, well clear of the next rising edge.
  task automatic drive(input logic h, input logic r, input logic b, input logic [W-1:0] t);
    @(negedge clock);
    halt = h; instr_ready = r; branch_enable = b; branch_target = t;
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic rd, input logic upd,
                         input logic set, input logic [W-1:0] pcv);
    chk({tag, " mem_read_enable"}, W'(mem_read_enable), W'(rd));
    chk({tag, " pc_update_enable"}, W'(pc_update_enable), W'(upd));
    chk({tag, " pc_set_enable"}, W'(pc_set_enable), W'(set));
    chk({tag, " pc_value"}, pc_value, pcv);
  endtask

  initial begin
    // cycle: halt ready br tgt | rd upd set pcv addr | valid out ipc cnt
    vecs[0]  = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0000, 0,16'h0000,16'h0000,16'd0}; // IDLE
    vecs[1]  = '{0,1,0,16'h0,    1,1,0,16'h1,    16'h0000, 0,16'h0000,16'h0000,16'd0}; // ISSUE 0
    vecs[2]  = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0001, 0,16'h0000,16'h0000,16'd0}; // WAIT
    vecs[3]  = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0001, 1,16'hA000,16'h0000,16'd0}; // HOLD
    vecs[4]  = '{0,1,0,16'h0,    1,1,0,16'h1,    16'h0001, 0,16'hA000,16'h0000,16'd1}; // ISSUE 1
    vecs[5]  = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0002, 0,16'hA000,16'h0000,16'd1};
    vecs[6]  = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0002, 1,16'hA001,16'h0001,16'd1};
    vecs[7]  = '{0,1,0,16'h0,    1,1,0,16'h1,    16'h0002, 0,16'hA001,16'h0001,16'd2}; // ISSUE 2
    vecs[8]  = '{0,1,1,16'h0040, 0,0,1,16'h0040, 16'h0003, 0,16'hA001,16'h0001,16'd2}; // branch in WAIT
    vecs[9]  = '{0,1,0,16'h0,    1,1,0,16'h1,    16'h0040, 0,16'hA001,16'h0001,16'd2};
    vecs[10] = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0041, 0,16'hA001,16'h0001,16'd2};
    vecs[11] = '{0,1,1,16'h0100, 0,0,1,16'h0100, 16'h0041, 1,16'hA040,16'h0040,16'd2}; // branch+ready in HOLD
    vecs[12] = '{0,1,0,16'h0,    1,1,0,16'h1,    16'h0100, 0,16'hA040,16'h0040,16'd3};
    vecs[13] = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0101, 0,16'hA040,16'h0040,16'd3};
    vecs[14] = '{0,1,0,16'h0,    0,0,0,16'h0,    16'h0101, 1,16'hA100,16'h0100,16'd3};
    vecs[15] = '{0,1,0,16'h0,    1,1,0,16'h1,    16'h0101, 0,16'hA100,16'h0100,16'd4};

    reset = 1'b1; pc_rst = 1'b1;
    halt = 1'b1; instr_ready = 1'b0; branch_enable = 1'b0; branch_target = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0; pc_rst = 1'b0;

    // Table: sequential fetch, branch in WAIT, branch with handshake in HOLD.
    for (int unsigned i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i].halt, vecs[i].ready, vecs[i].br, vecs[i].tgt);
      chk_ctl(tag, vecs[i].rd, vecs[i].upd, vecs[i].set, vecs[i].pcv);
      chk({tag, " mem_address"}, mem_address, vecs[i].addr);
      chk({tag, " instr_valid"}, W'(instr_valid), W'(vecs[i].valid));
      chk({tag, " instr_out"}, instr_out, vecs[i].out);
      chk({tag, " instr_pc"}, instr_pc, vecs[i].ipc);
      chk({tag, " fetch_count"}, fetch_count, vecs[i].cnt);
    end

    // Back-pressure: decode stalls five cycles in HOLD.
    drive(0, 1, 0, '0);                         // WAIT for 0x0101
    for (int unsigned i = 0; i < 5; i++) begin
      drive(0, 0, 0, '0);
      chk("stall instr_valid", W'(instr_valid), W'(1));
      chk("stall instr_out", instr_out, 16'hA101);
      chk_ctl("stall", 0, 0, 0, '0);
      chk("stall pc", pc, 16'h0102);
      chk("stall fetch_count", fetch_count, 16'd4);
    end
    drive(0, 1, 0, '0);                         // handshake
    drive(0, 1, 0, '0);
    chk("post-stall fetch_count", fetch_count, 16'd5);
    chk("post-stall instr_valid", W'(instr_valid), W'(0));
    chk_ctl("post-stall issue", 1, 1, 0, 16'h1);
    chk("post-stall mem_address", mem_address, 16'h0102);

    // Halt sampled at the HOLD handshake.
    drive(0, 1, 0, '0);                         // WAIT
    drive(1, 1, 0, '0);                         // HOLD, handshake with halt
    chk("halt hold instr_out", instr_out, 16'hA102);
    for (int unsigned i = 0; i < 10; i++) begin
      drive(1, 1, 0, '0);
      chk_ctl("halted", 0, 0, 0, '0);
      chk("halted pc", pc, 16'h0103);
      chk("halted instr_valid", W'(instr_valid), W'(0));
    end
    chk("halted fetch_count", fetch_count, 16'd6);
    drive(0, 1, 0, '0);                         // IDLE sees halt=0
    chk_ctl("unhalt idle", 0, 0, 0, '0);
    drive(0, 0, 0, '0);
    chk_ctl("unhalt issue", 1, 1, 0, 16'h1);
    chk("unhalt mem_address", mem_address, 16'h0103);

    // Branch in HOLD without ready: instruction dropped, not counted.
    drive(0, 0, 0, '0);                         // WAIT
    drive(0, 0, 1, 16'h0200);                   // HOLD
    chk("hold-branch instr_valid", W'(instr_valid), W'(1));
    chk_ctl("hold-branch", 0, 0, 1, 16'h0200);
    drive(0, 0, 0, '0);
    chk("dropped instr_valid", W'(instr_valid), W'(0));
    chk("dropped fetch_count", fetch_count, 16'd6);
    chk_ctl("dropped issue", 1, 1, 0, 16'h1);
    chk("dropped mem_address", mem_address, 16'h0200);

    // Reset during WAIT, with branch_enable held high.
    drive(0, 0, 0, '0);                         // WAIT
    @(negedge clock);
    reset = 1'b1; branch_enable = 1'b1; branch_target = 16'h0300;
    #1;
    chk_ctl("reset-cycle", 0, 0, 0, '0);
    drive(0, 1, 1, 16'h0300);                   // still in reset
    chk_ctl("in-reset", 0, 0, 0, '0);
    chk("in-reset instr_valid", W'(instr_valid), W'(0));
    chk("in-reset fetch_count", fetch_count, 16'd0);
    chk("in-reset instr_out", instr_out, 16'h0000);
    @(negedge clock);
    reset = 1'b0; halt = 1'b1; branch_enable = 1'b0;
    #1;
    chk_ctl("post-reset idle", 0, 0, 0, '0);
    chk("post-reset pc", pc, 16'h0201);

    // Redirect from IDLE to 0xFFFF, then wrap to 0x0000.
    drive(0, 1, 1, 16'hFFFF);
    chk_ctl("wrap redirect", 0, 0, 1, 16'hFFFF);
    drive(0, 1, 0, '0);
    chk_ctl("wrap issue", 1, 1, 0, 16'h1);
    chk("wrap mem_address", mem_address, 16'hFFFF);
    drive(0, 1, 0, '0);
    chk("wrapped pc", pc, 16'h0000);
    drive(0, 1, 0, '0);
    chk("wrap instr_out", instr_out, 16'hFFFF);
    chk("wrap instr_pc", instr_pc, 16'hFFFF);
    chk("wrap fetch_count", fetch_count, 16'd0);
    drive(0, 1, 0, '0);
    chk("after-wrap mem_address", mem_address, 16'h0000);
    chk("after-wrap fetch_count", fetch_count, 16'd1);
    drive(0, 1, 0, '0);
    drive(0, 1, 0, '0);
    chk("after-wrap instr_out", instr_out, 16'hA000);
    chk("after-wrap instr_pc", instr_pc, 16'h0000);
    chk("after-wrap instr_valid", W'(instr_valid), W'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
